regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised next-generation register file for the pipelined core.
- Read ports: two combinational, with same-cycle writeback bypass.
- Write port: one, on the rising clock edge.
- Per-register scoreboard counts outstanding in-flight writes, so the hazard unit can stall decode directly without comparing destinations across stages.
- Sits between decode (reads, issue) and writeback (write, retire).

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 4, register address width.
- NUM_REGS, 15, number of implemented registers (must be ≤ 2^ADDR_W). Addresses ≥ NUM_REGS are unimplemented.
- CNT_W, 2, width of each per-register outstanding-write counter. Maximum count is 2^CNT_W−1.
- RESET_INDEX, 1, if 1 register i resets to value i; if 0 all registers reset to 0.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data.
- rd_data2  out  DATA_W  read port 2 data.
- hazard1  out  1  port 1 operand not yet available.
- hazard2  out  1  port 2 operand not yet available.
- wb_en  in  1  writeback valid.
- wb_addr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback data.
- iss_en  in  1  decode issues an instruction that will write iss_dest.
- iss_dest  in  ADDR_W  destination of the issued instruction.
- iss_full  out  1  counter of iss_dest is at maximum; the issue is refused.
- err_underflow  out  1  sticky: a writeback retired to a register with count 0.

Behaviour:
- Reset (async, rst=1):
  - registers[i] = RESET_INDEX ? i : 0.
  - All counters = 0; err_underflow = 0.
  - rd_dataN reflects reset contents combinationally; hazardN = 0; iss_full = 0.
- Read (combinational, zero latency):
  - rd_dataN = 0 if rd_addrN ≥ NUM_REGS.
  - Otherwise, if wb_en and wb_addr == rd_addrN, rd_dataN = wb_data (bypass).
  - Otherwise rd_dataN = registers[rd_addrN].
- Write: on the rising edge, if wb_en and wb_addr < NUM_REGS, registers[wb_addr] <= wb_data. Out-of-range writes are ignored.
- Counters (rising edge, per register r):
  - inc = iss_en && iss_dest == r && !iss_full.
  - dec = wb_en && wb_addr == r && cnt[r] != 0.
  - inc && !dec: +1. dec && !inc: −1. Both: unchanged.
  - Out-of-range iss_dest or wb_addr never changes any counter.
- iss_full (combinational) = iss_en && iss_dest < NUM_REGS && cnt[iss_dest] == max.
  - Evaluated on the current count only: a same-cycle writeback to that register does not lift the refusal.
  - Decode must hold the instruction while iss_full = 1.
- Underflow:
  - Writeback to an in-range register with cnt = 0 still writes data, leaves the count at 0, and sets err_underflow at the edge.
  - err_underflow clears only on rst.
- hazardN (combinational):
  - hazardN = rd_addrN < NUM_REGS && cnt[rd_addrN] != 0, except when the count is exactly 1.
  - When cnt[rd_addrN] == 1 and wb_en && wb_addr == rd_addrN this cycle, hazardN = 0: the bypass supplies the final value.
  - With count ≥ 2, hazardN stays 1 even during a matching writeback, because an older write is retiring and a younger one is still in flight.
- Issue and read in the same cycle to the same register: hazard reflects the count before the issue. Ordering is decode's responsibility.
- Reset mid-operation: all pending counts are discarded immediately and registers return to reset values. No partial write occurs in the reset cycle.

Test Plan:
- Reset with RESET_INDEX=1: release rst, set rd_addr1=7, rd_addr2=14 → rd_data1=7, rd_data2=14, hazards 0, err_underflow 0.
- Bypass and write: wb_en=1, wb_addr=3, wb_data=0xDEADBEEF, rd_addr1=3 → rd_data1=0xDEADBEEF in the same cycle. Next cycle with wb_en=0 → still 0xDEADBEEF.
- Scoreboard path:
  - Issue dest 5 twice → cnt=2, hazard1=1 for rd_addr1=5.
  - Writeback 5 → hazard1 stays 1 that cycle.
  - Second writeback 5 → hazard1=0 in that cycle, with rd_data1 = the second wb_data.
- Saturation (CNT_W=2): issue dest 2 three times → cnt=3. Fourth issue gives iss_full=1 and the count stays 3. Fourth issue with a simultaneous wb to 2 → iss_full=1, count becomes 2.
- Out-of-range and underflow:
  - rd_addr1=15 → rd_data1=0. Write to 15 → no effect. Issue to 15 → iss_full=0, no counter change.
  - wb to register 9 with cnt 0 → data written, err_underflow=1 until rst.
- Async reset mid-flight: with cnt[4]=2 and reg 4 overwritten, assert rst between edges → rd_data for 4 = 4 immediately, hazard=0, and a subsequent wb 4 sets err_underflow.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two bypassed combinational read ports, one write port, and a
// per-register count of in-flight writes so decode can detect hazards directly.
module regfile_scoreboard #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 15,
    parameter int CNT_W       = 2,
    parameter int RESET_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              hazard1,
    output logic              hazard2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              iss_full,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d  [NUM_REGS];
    logic                err_q;

    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] iss_hit;
    logic [NUM_REGS-1:0] rd1_hit;
    logic [NUM_REGS-1:0] rd2_hit;
    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] hz1_vec;
    logic [NUM_REGS-1:0] hz2_vec;
    logic [NUM_REGS-1:0] uf_vec;

    // Address decode against implemented registers only; an address that matches
    // no slice is out of range and therefore touches nothing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic inc;
            logic dec;

            assign wb_hit[gi]   = wb_en  && (wb_addr  == IDX);
            assign iss_hit[gi]  = iss_en && (iss_dest == IDX);
            assign rd1_hit[gi]  = (rd_addr1 == IDX);
            assign rd2_hit[gi]  = (rd_addr2 == IDX);
            assign full_vec[gi] = iss_hit[gi] && (cnt_q[gi] == CNT_MAX);
            assign uf_vec[gi]   = wb_hit[gi] && (cnt_q[gi] == '0);

            // Count of one plus a retiring writeback means the bypass carries the final value.
            assign hz1_vec[gi] = rd1_hit[gi] && (cnt_q[gi] != '0)
                                 && !((cnt_q[gi] == CNT_ONE) && wb_hit[gi]);
            assign hz2_vec[gi] = rd2_hit[gi] && (cnt_q[gi] != '0)
                                 && !((cnt_q[gi] == CNT_ONE) && wb_hit[gi]);

            assign inc = iss_hit[gi] && !iss_full;
            assign dec = wb_hit[gi] && (cnt_q[gi] != '0);
            assign cnt_d[gi] = (inc && !dec) ? cnt_q[gi] + CNT_ONE :
                               (dec && !inc) ? cnt_q[gi] - CNT_ONE : cnt_q[gi];
        end
    endgenerate

    assign iss_full      = |full_vec;
    assign hazard1       = |hz1_vec;
    assign hazard2       = |hz2_vec;
    assign err_underflow = err_q;

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rd1_hit[r]) rd_data1 = wb_hit[r] ? wb_data : regs_q[r];
            if (rd2_hit[r]) rd_data2 = wb_hit[r] ? wb_data : regs_q[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= (RESET_INDEX != 0) ? DATA_W'(r) : '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wb_hit[r]) regs_q[r] <= wb_data;
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_q | (|uf_vec);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven check of reads, bypass, scoreboard counting, saturation, range
// handling, underflow and asynchronous reset of regfile_scoreboard.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2, wb_addr, iss_dest;
    logic [31:0] rd_data1, rd_data2, wb_data;
    logic        hazard1, hazard2, wb_en, iss_en, iss_full, err_underflow;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        logic        iss_en;
        logic [3:0]  iss_dest;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_h1;
        logic        e_h2;
        logic        e_full;
        logic        e_err;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];
    vec_t exp_q [$];

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .hazard1(hazard1), .hazard2(hazard2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_dest(iss_dest),
        .iss_full(iss_full), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [31:0] wd,
                                logic ie, logic [3:0] id, logic [3:0] a1, logic [3:0] a2,
                                logic [31:0] d1, logic [31:0] d2,
                                logic h1, logic h2, logic fu, logic er);
        vec_t v;
        v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
        v.iss_en = ie; v.iss_dest = id; v.ra1 = a1; v.ra2 = a2;
        v.e_d1 = d1; v.e_d2 = d2; v.e_h1 = h1; v.e_h2 = h2;
        v.e_full = fu; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive at the falling edge, check combinational outputs 1ns later, commit at the next rising edge.
    task automatic apply(input int i);
        vec_t e;
        @(negedge clk);
        wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
        iss_en = vecs[i].iss_en; iss_dest = vecs[i].iss_dest;
        rd_addr1 = vecs[i].ra1; rd_addr2 = vecs[i].ra2;
        exp_q.push_back(vecs[i]);
        #1;
        e = exp_q.pop_front();
        chk("rd_data1", i, rd_data1, e.e_d1);
        chk("rd_data2", i, rd_data2, e.e_d2);
        chk("hazard1", i, 32'(hazard1), 32'(e.e_h1));
        chk("hazard2", i, 32'(hazard2), 32'(e.e_h2));
        chk("iss_full", i, 32'(iss_full), 32'(e.e_full));
        chk("err_underflow", i, 32'(err_underflow), 32'(e.e_err));
        $display("[TB] vec %0d: rd1=%h rd2=%h hz=%b%b full=%b err=%b",
                 i, rd_data1, rd_data2, hazard1, hazard2, iss_full, err_underflow);
    endtask

    initial begin
        //               we wa  wdata         ie id  a1  a2   d1            d2            h1 h2 fu er
        vecs[0]  = mk(0, 0,  32'h0,        0, 0,  7,  14,  32'd7,        32'd14,       0, 0, 0, 0);
        vecs[1]  = mk(0, 0,  32'h0,        1, 3,  3,  0,   32'd3,        32'd0,        0, 0, 0, 0);
        vecs[2]  = mk(1, 3,  32'hDEADBEEF, 0, 0,  3,  3,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0,  32'h0,        0, 0,  3,  7,   32'hDEADBEEF, 32'd7,        0, 0, 0, 0);
        vecs[4]  = mk(0, 0,  32'h0,        1, 5,  5,  3,   32'd5,        32'hDEADBEEF, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0,  32'h0,        1, 5,  5,  5,   32'd5,        32'd5,        1, 1, 0, 0);
        vecs[6]  = mk(0, 0,  32'h0,        0, 0,  5,  6,   32'd5,        32'd6,        1, 0, 0, 0);
        vecs[7]  = mk(1, 5,  32'h11111111, 0, 0,  5,  5,   32'h11111111, 32'h11111111, 1, 1, 0, 0);
        vecs[8]  = mk(1, 5,  32'h22222222, 0, 0,  5,  4,   32'h22222222, 32'd4,        0, 0, 0, 0);
        vecs[9]  = mk(0, 0,  32'h0,        0, 0,  5,  1,   32'h22222222, 32'd1,        0, 0, 0, 0);
        vecs[10] = mk(0, 0,  32'h0,        1, 2,  2,  1,   32'd2,        32'd1,        0, 0, 0, 0);
        vecs[11] = mk(0, 0,  32'h0,        1, 2,  2,  1,   32'd2,        32'd1,        1, 0, 0, 0);
        vecs[12] = mk(0, 0,  32'h0,        1, 2,  2,  1,   32'd2,        32'd1,        1, 0, 0, 0);
        vecs[13] = mk(0, 0,  32'h0,        1, 2,  2,  1,   32'd2,        32'd1,        1, 0, 1, 0);
        vecs[14] = mk(1, 2,  32'hA5A5A5A5, 1, 2,  2,  2,   32'hA5A5A5A5, 32'hA5A5A5A5, 1, 1, 1, 0);
        vecs[15] = mk(1, 2,  32'h0000000B, 0, 0,  2,  1,   32'h0000000B, 32'd1,        1, 0, 0, 0);
        vecs[16] = mk(1, 2,  32'h0000000C, 0, 0,  2,  1,   32'h0000000C, 32'd1,        0, 0, 0, 0);
        vecs[17] = mk(0, 0,  32'h0,        0, 0,  2,  15,  32'h0000000C, 32'd0,        0, 0, 0, 0);
        vecs[18] = mk(1, 15, 32'hFFFFFFFF, 0, 0,  15, 14,  32'd0,        32'd14,       0, 0, 0, 0);
        vecs[19] = mk(0, 0,  32'h0,        1, 15, 15, 14,  32'd0,        32'd14,       0, 0, 0, 0);
        vecs[20] = mk(0, 0,  32'h0,        0, 0,  14, 15,  32'd14,       32'd0,        0, 0, 0, 0);
        vecs[21] = mk(1, 9,  32'h00000099, 0, 0,  9,  9,   32'h00000099, 32'h00000099, 0, 0, 0, 0);
        vecs[22] = mk(0, 0,  32'h0,        0, 0,  9,  8,   32'h00000099, 32'd8,        0, 0, 0, 1);
        vecs[23] = mk(0, 0,  32'h0,        1, 4,  4,  8,   32'd4,        32'd8,        0, 0, 0, 1);
        vecs[24] = mk(0, 0,  32'h0,        1, 4,  4,  8,   32'd4,        32'd8,        1, 0, 0, 1);
        vecs[25] = mk(1, 4,  32'h00000044, 1, 4,  4,  4,   32'h00000044, 32'h00000044, 1, 1, 0, 1);
        vecs[26] = mk(0, 0,  32'h0,        0, 0,  4,  8,   32'h00000044, 32'd8,        1, 0, 0, 1);
        // After the mid-flight reset: reg 4 back to 4 with count 0, so a writeback underflows.
        vecs[27] = mk(1, 4,  32'h00000077, 0, 0,  4,  8,   32'h00000077, 32'd8,        0, 0, 0, 0);
        vecs[28] = mk(0, 0,  32'h0,        0, 0,  4,  8,   32'h00000077, 32'd8,        0, 0, 0, 1);

        rst = 1'b1;
        wb_en = 0; wb_addr = 0; wb_data = 0; iss_en = 0; iss_dest = 0;
        rd_addr1 = 4'd7; rd_addr2 = 4'd14;
        #2;
        chk("reset_rd_data1", -1, rd_data1, 32'd7);
        chk("reset_rd_data2", -1, rd_data2, 32'd14);
        chk("reset_err", -1, 32'(err_underflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i <= 26; i++) apply(i);

        // Asynchronous reset asserted between edges while reg 4 has two writes in flight.
        #1;
        rd_addr1 = 4'd4; rd_addr2 = 4'd5;
        wb_en = 0; iss_en = 0;
        rst = 1'b1;
        #1;
        chk("async_rst_rd_data1", -2, rd_data1, 32'd4);
        chk("async_rst_rd_data2", -2, rd_data2, 32'd5);
        chk("async_rst_hazard1", -2, 32'(hazard1), 32'd0);
        chk("async_rst_err", -2, 32'(err_underflow), 32'd0);
        $display("[TB] async reset: rd1=%h rd2=%h hz1=%b err=%b", rd_data1, rd_data2, hazard1, err_underflow);
        #1;
        rst = 1'b0;

        for (int i = 27; i < NV; i++) apply(i);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
